// File: rtl/riscv_base_mul_issue_ctrl.sv
// Issue controller for a shared pipelined multiplier.
// Two requesters are arbitrated round-robin. A tag pipeline that matches the
// multiplier latency tracks in-flight destinations, so that RAW hazards can be
// blocked. The writeback port backpressures the multiplier through mul_hold_o.
module riscv_base_mul_issue_ctrl #(
  // Issue-to-result latency of the attached multiplier (2 or 3)
  parameter int MULT_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  input  logic [31:0] req0_opcode_i,
  input  logic [4:0]  req0_rd_idx_i,
  input  logic [4:0]  req0_ra_idx_i,
  input  logic [4:0]  req0_rb_idx_i,
  input  logic [31:0] req0_ra_operand_i,
  input  logic [31:0] req0_rb_operand_i,
  output logic        req0_ready_o,

  input  logic        req1_valid_i,
  input  logic [31:0] req1_opcode_i,
  input  logic [4:0]  req1_rd_idx_i,
  input  logic [4:0]  req1_ra_idx_i,
  input  logic [4:0]  req1_rb_idx_i,
  input  logic [31:0] req1_ra_operand_i,
  input  logic [31:0] req1_rb_operand_i,
  output logic        req1_ready_o,

  output logic        mul_opcode_valid_o,
  output logic [31:0] mul_opcode_opcode_o,
  output logic [4:0]  mul_rd_idx_o,
  output logic [4:0]  mul_ra_idx_o,
  output logic [4:0]  mul_rb_idx_o,
  output logic [31:0] mul_ra_operand_o,
  output logic [31:0] mul_rb_operand_o,
  output logic        mul_hold_o,
  input  logic [31:0] mul_result_i,

  output logic        wb_valid_o,
  output logic [31:0] wb_value_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic        wb_src_o,
  input  logic        wb_ready_i,

  output logic        busy_o
);

  localparam int LAST = MULT_STAGES - 1;

  // Tag pipeline: one entry per multiplier stage. The last entry is the writeback slot.
  logic [MULT_STAGES-1:0]      tag_valid_reg;
  logic [MULT_STAGES-1:0][4:0] tag_rd_reg;
  logic [MULT_STAGES-1:0]      tag_src_reg;

  // Round-robin pointer: the requester that was granted most recently
  logic last_grant_reg;

  logic hold;
  logic [MULT_STAGES-1:0] haz0_vec;
  logic [MULT_STAGES-1:0] haz1_vec;
  logic elig0, elig1;
  logic gnt0, gnt1;
  logic issue;

  // MUL/MULH/MULHSU/MULHU only. The divide group (funct3[2]=1) is not for this unit.
  function automatic logic is_mul_op(input logic [31:0] op);
    return (op[6:0] == 7'b0110011) && (op[31:25] == 7'b0000001) && !op[14];
  endfunction

  assign hold       = tag_valid_reg[LAST] & ~wb_ready_i;
  assign mul_hold_o = hold;

  // Per-stage RAW compare. x0 never creates a dependency on either side.
  for (genvar gi = 0; gi < MULT_STAGES; gi++) begin : g_hazard
    assign haz0_vec[gi] = tag_valid_reg[gi] && (tag_rd_reg[gi] != 5'd0) &&
                          (((req0_ra_idx_i != 5'd0) && (req0_ra_idx_i == tag_rd_reg[gi])) ||
                           ((req0_rb_idx_i != 5'd0) && (req0_rb_idx_i == tag_rd_reg[gi])));
    assign haz1_vec[gi] = tag_valid_reg[gi] && (tag_rd_reg[gi] != 5'd0) &&
                          (((req1_ra_idx_i != 5'd0) && (req1_ra_idx_i == tag_rd_reg[gi])) ||
                           ((req1_rb_idx_i != 5'd0) && (req1_rb_idx_i == tag_rd_reg[gi])));
  end

  // No grant while reset is asserted, so every output stays quiet through reset.
  assign elig0 = req0_valid_i & ~(|haz0_vec) & ~hold & ~rst_i;
  assign elig1 = req1_valid_i & ~(|haz1_vec) & ~hold & ~rst_i;

  // On a tie, the requester that was not granted last time wins.
  assign gnt0 = elig0 & (~elig1 | last_grant_reg);
  assign gnt1 = elig1 & (~elig0 | ~last_grant_reg);

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Steer the granted request onto the multiplier port. The port is zero when idle.
  always_comb begin
    issue               = 1'b0;
    mul_opcode_opcode_o = 32'd0;
    mul_rd_idx_o        = 5'd0;
    mul_ra_idx_o        = 5'd0;
    mul_rb_idx_o        = 5'd0;
    mul_ra_operand_o    = 32'd0;
    mul_rb_operand_o    = 32'd0;
    if (gnt0) begin
      issue               = is_mul_op(req0_opcode_i);
      mul_opcode_opcode_o = req0_opcode_i;
      mul_rd_idx_o        = req0_rd_idx_i;
      mul_ra_idx_o        = req0_ra_idx_i;
      mul_rb_idx_o        = req0_rb_idx_i;
      mul_ra_operand_o    = req0_ra_operand_i;
      mul_rb_operand_o    = req0_rb_operand_i;
    end else if (gnt1) begin
      issue               = is_mul_op(req1_opcode_i);
      mul_opcode_opcode_o = req1_opcode_i;
      mul_rd_idx_o        = req1_rd_idx_i;
      mul_ra_idx_o        = req1_ra_idx_i;
      mul_rb_idx_o        = req1_rb_idx_i;
      mul_ra_operand_o    = req1_ra_operand_i;
      mul_rb_operand_o    = req1_rb_operand_i;
    end
  end

  assign mul_opcode_valid_o = issue;

  // Remember the last grant. Reset points it at req1, so req0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_reg <= 1'b1;
    end else if (gnt0) begin
      last_grant_reg <= 1'b0;
    end else if (gnt1) begin
      last_grant_reg <= 1'b1;
    end
  end

  // Advance the tag pipeline in lockstep with the multiplier. Freeze it while writeback stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_valid_reg <= '0;
      tag_rd_reg    <= '0;
      tag_src_reg   <= '0;
    end else if (!hold) begin
      tag_valid_reg[0] <= issue;
      tag_rd_reg[0]    <= issue ? mul_rd_idx_o : 5'd0;
      tag_src_reg[0]   <= issue & gnt1;
      for (int i = 1; i < MULT_STAGES; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_rd_reg[i]    <= tag_rd_reg[i-1];
        tag_src_reg[i]   <= tag_src_reg[i-1];
      end
    end
  end

  // The multiplier is frozen by hold too, so its result stays stable while the slot waits.
  assign wb_valid_o  = tag_valid_reg[LAST];
  assign wb_rd_idx_o = tag_rd_reg[LAST];
  assign wb_src_o    = tag_src_reg[LAST];
  assign wb_value_o  = mul_result_i;
  assign busy_o      = |tag_valid_reg;

endmodule

// File: tb/tb_riscv_base_mul_issue_ctrl.sv
// Bench for riscv_base_mul_issue_ctrl.
// A behavioural multiplier with matching latency drives the result input.
// Expected writebacks are queued at issue time, and a monitor pops and compares
// them whenever a result retires.
module tb_riscv_base_mul_issue_ctrl;

  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_opcode, req1_opcode;
  logic [4:0]  req0_rd, req0_ra, req0_rb, req1_rd, req1_ra, req1_rb;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        mul_valid;
  logic [31:0] mul_opcode;
  logic [4:0]  mul_rd, mul_ra, mul_rb;
  logic [31:0] mul_a, mul_b;
  logic        mul_hold;
  logic [31:0] mul_result;
  logic        wb_valid;
  logic [31:0] wb_value;
  logic [4:0]  wb_rd;
  logic        wb_src;
  logic        wb_ready;
  logic        busy;

  always #5 clk = ~clk;

  riscv_base_mul_issue_ctrl #(.MULT_STAGES(MS)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_opcode_i(req0_opcode),
    .req0_rd_idx_i(req0_rd), .req0_ra_idx_i(req0_ra), .req0_rb_idx_i(req0_rb),
    .req0_ra_operand_i(req0_a), .req0_rb_operand_i(req0_b), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_opcode_i(req1_opcode),
    .req1_rd_idx_i(req1_rd), .req1_ra_idx_i(req1_ra), .req1_rb_idx_i(req1_rb),
    .req1_ra_operand_i(req1_a), .req1_rb_operand_i(req1_b), .req1_ready_o(req1_ready),
    .mul_opcode_valid_o(mul_valid), .mul_opcode_opcode_o(mul_opcode),
    .mul_rd_idx_o(mul_rd), .mul_ra_idx_o(mul_ra), .mul_rb_idx_o(mul_rb),
    .mul_ra_operand_o(mul_a), .mul_rb_operand_o(mul_b),
    .mul_hold_o(mul_hold), .mul_result_i(mul_result),
    .wb_valid_o(wb_valid), .wb_value_o(wb_value), .wb_rd_idx_o(wb_rd),
    .wb_src_o(wb_src), .wb_ready_i(wb_ready),
    .busy_o(busy)
  );

  // Behavioural stand-in for the pipelined multiplier (shares reset, obeys hold)
  function automatic logic [31:0] mul_fn(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op[13:12])
      2'd1:    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'd2:    p = {{32{a[31]}}, a} * {32'd0, b};
      default: p = {32'd0, a} * {32'd0, b};
    endcase
    return (op[13:12] == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  logic [31:0] mpipe [MS];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MS; i++) mpipe[i] <= 32'd0;
    end else if (!mul_hold) begin
      mpipe[0] <= mul_valid ? mul_fn(mul_opcode, mul_a, mul_b) : 32'd0;
      for (int i = 1; i < MS; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_result = mpipe[MS-1];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        src;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every retiring writeback is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got rd=%0d val=0x%08h src=%0d, expected none", wb_rd, wb_value, wb_src);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        $display("wb rd=%0d val=0x%08h src=%0d (exp rd=%0d val=0x%08h src=%0d)",
                 wb_rd, wb_value, wb_src, e.rd, e.val, e.src);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_value", wb_value, e.val);
        chk("wb_src", {31'd0, wb_src}, {31'd0, e.src});
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd0, 5'd0, f3, 5'd0, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr();
    req0_valid = 0; req0_opcode = 0; req0_rd = 0; req0_ra = 0; req0_rb = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_rd = 0; req1_ra = 0; req1_rb = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic drv(input int n, input logic [31:0] op, input logic [4:0] rd, input logic [4:0] ra,
                     input logic [4:0] rb, input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = 1; req0_opcode = op; req0_rd = rd; req0_ra = ra; req0_rb = rb; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1; req1_opcode = op; req1_rd = rd; req1_ra = ra; req1_rb = rb; req1_a = a; req1_b = b;
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val, input logic src);
    wb_exp_t e;
    e.rd = rd; e.val = val; e.src = src;
    sb.push_back(e);
  endtask

  logic [31:0] MUL, MULH, MULHSU, MULHU, ADD, DIVOP;

  initial begin
    MUL = mk(7'b0000001, 3'b000);  MULH = mk(7'b0000001, 3'b001);
    MULHSU = mk(7'b0000001, 3'b010); MULHU = mk(7'b0000001, 3'b011);
    ADD = mk(7'b0000000, 3'b000);  DIVOP = mk(7'b0000001, 3'b100);
    rst = 1; wb_ready = 1; clr();

    // Reset with a pending request: every output is quiet after the reset edge
    tick(); rst = 1; drv(0, MUL, 5'd3, 5'd1, 5'd2, 32'd7, 32'd6); sb.delete();
    tick(); sample();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_mul_valid", {31'd0, mul_valid}, 32'd0);
    chk("rst_hold", {31'd0, mul_hold}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick(); rst = 0; clr();

    // Single MUL: 7*6 written back MS cycles after issue, then idle
    tick(); drv(0, MUL, 5'd3, 5'd1, 5'd2, 32'd7, 32'd6); sample();
    chk("t1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t1_mul_valid", {31'd0, mul_valid}, 32'd1);
    chk("t1_mul_a", mul_a, 32'd7);
    push(5'd3, 32'd42, 1'b0);
    tick(); clr(); sample();
    chk("t1_idle_mul_a", mul_a, 32'd0);
    tick(); sample();
    chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_wb_value", wb_value, 32'd42);
    tick(); sample();
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // Fresh reset, then both requesters every cycle: grants alternate starting with req0
    tick(); rst = 1; sb.delete();
    tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drv(0, MUL, 5'd10, 5'd1, 5'd2, 32'd2, 32'd3);
      drv(1, MUL, 5'd11, 5'd4, 5'd5, 32'd4, 32'd5);
      sample();
      chk("t2_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 0) push(5'd10, 32'd6, 1'b0); else push(5'd11, 32'd20, 1'b1);
      if (i >= 2) chk("t2_wb_b2b", {31'd0, wb_valid}, 32'd1);
    end
    tick(); clr(); sample();
    chk("t2_wb_b2b", {31'd0, wb_valid}, 32'd1);
    tick(); sample();
    chk("t2_wb_b2b", {31'd0, wb_valid}, 32'd1);

    // RAW hazard: consumer of rd=5 waits until the producer has retired
    tick(); drv(0, MUL, 5'd5, 5'd1, 5'd2, 32'd3, 32'd4); sample();
    chk("t3_prod_ready", {31'd0, req0_ready}, 32'd1);
    push(5'd5, 32'd12, 1'b0);
    tick(); drv(0, MUL, 5'd6, 5'd5, 5'd2, 32'd5, 32'd5); sample();
    chk("t3_dep_stall1", {31'd0, req0_ready}, 32'd0);
    tick(); sample();
    chk("t3_dep_stall2", {31'd0, req0_ready}, 32'd0);
    chk("t3_prod_wb_rd", {27'd0, wb_rd}, 32'd5);
    tick(); sample();
    chk("t3_dep_go", {31'd0, req0_ready}, 32'd1);
    push(5'd6, 32'd25, 1'b0);
    tick(); drv(0, MUL, 5'd0, 5'd1, 5'd2, 32'd2, 32'd2); sample();
    chk("t3_rd0_prod", {31'd0, req0_ready}, 32'd1);
    push(5'd0, 32'd4, 1'b0);
    tick(); drv(0, MUL, 5'd7, 5'd0, 5'd0, 32'd3, 32'd3); sample();
    chk("t3_rd0_nostall", {31'd0, req0_ready}, 32'd1);
    push(5'd7, 32'd9, 1'b0);
    tick(); clr();
    repeat (3) tick();

    // Writeback backpressure for 3 cycles: hold, stable wb, no grants, delayed follower
    tick(); drv(0, MUL, 5'd8, 5'd1, 5'd2, 32'd2, 32'd5); sample();
    chk("t4_x_ready", {31'd0, req0_ready}, 32'd1);
    push(5'd8, 32'd10, 1'b0);
    tick(); drv(0, MUL, 5'd9, 5'd1, 5'd2, 32'd3, 32'd5); sample();
    chk("t4_y_ready", {31'd0, req0_ready}, 32'd1);
    push(5'd9, 32'd15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); wb_ready = 0;
      drv(0, MUL, 5'd12, 5'd1, 5'd2, 32'd1, 32'd1);
      drv(1, MUL, 5'd13, 5'd3, 5'd4, 32'd1, 32'd1);
      sample();
      chk("t4_hold", {31'd0, mul_hold}, 32'd1);
      chk("t4_ready0", {31'd0, req0_ready}, 32'd0);
      chk("t4_ready1", {31'd0, req1_ready}, 32'd0);
      chk("t4_wb_rd", {27'd0, wb_rd}, 32'd8);
      chk("t4_wb_value", wb_value, 32'd10);
    end
    tick(); wb_ready = 1; clr(); sample();
    chk("t4_release_hold", {31'd0, mul_hold}, 32'd0);
    chk("t4_release_rd", {27'd0, wb_rd}, 32'd8);
    tick(); sample();
    chk("t4_y_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4_y_wb_rd", {27'd0, wb_rd}, 32'd9);
    tick(); tick();

    // High-half variants and non-mul ops that are accepted but never written back
    tick(); drv(0, MULHU, 5'd1, 5'd10, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF); sample();
    push(5'd1, 32'hFFFFFFFE, 1'b0);
    tick(); clr(); drv(1, MULH, 5'd2, 5'd12, 5'd13, 32'hFFFFFFFF, 32'h00000002); sample();
    chk("t5_mulh_ready1", {31'd0, req1_ready}, 32'd1);
    push(5'd2, 32'hFFFFFFFF, 1'b1);
    tick(); clr(); drv(0, MULHSU, 5'd3, 5'd10, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF); sample();
    push(5'd3, 32'hFFFFFFFF, 1'b0);
    tick(); clr(); drv(1, ADD, 5'd4, 5'd10, 5'd11, 32'd1, 32'd1); sample();
    chk("t5_add_ready1", {31'd0, req1_ready}, 32'd1);
    chk("t5_add_no_issue", {31'd0, mul_valid}, 32'd0);
    tick(); clr(); drv(0, DIVOP, 5'd5, 5'd10, 5'd11, 32'd9, 32'd3); sample();
    chk("t5_div_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t5_div_no_issue", {31'd0, mul_valid}, 32'd0);
    tick(); clr(); sample();
    chk("t5_busy_none", {31'd0, busy}, 32'd0);

    // Reset with two ops in flight: both discarded, and the first tie goes to req0
    tick(); drv(0, MUL, 5'd20, 5'd1, 5'd2, 32'd6, 32'd7); sample();
    chk("t6_op0_ready", {31'd0, req0_ready}, 32'd1);
    tick(); clr(); drv(1, MUL, 5'd21, 5'd3, 5'd4, 32'd8, 32'd8); sample();
    chk("t6_op1_ready", {31'd0, req1_ready}, 32'd1);
    tick(); clr(); rst = 1; wb_ready = 0; sb.delete();
    tick(); rst = 0; wb_ready = 1; sample();
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_wb_valid", {31'd0, wb_valid}, 32'd0);
    tick();
    drv(0, MUL, 5'd22, 5'd1, 5'd2, 32'd2, 32'd3);
    drv(1, MUL, 5'd23, 5'd3, 5'd4, 32'd4, 32'd4);
    sample();
    chk("t6_tie_ready0", {31'd0, req0_ready}, 32'd1);
    chk("t6_tie_ready1", {31'd0, req1_ready}, 32'd0);
    push(5'd22, 32'd6, 1'b0);
    tick(); clr();
    repeat (5) tick();
    sample();
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
